// File: rtl/ps2_scan.sv
// PS/2 keyboard front end: pin sync, clock filter, frame deframer, prefix fold, event FIFO.
// Define PS2_TIMEOUT_EN to build the mid-frame stall timeout.
`timescale 1ns/1ps

module ps2_scan #(
  parameter int FILTER  = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 7000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       valid,
  output logic [7:0] code,
  output logic       ext,
  output logic       brk,
  input  logic       rd,
  output logic       perr,
  output logic       ovf
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (FILTER < 1 || FILTER > 15 || DEPTH < 2 || DEPTH > 16 ||
      (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad
    $error("ps2_scan: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          sclk;
  logic          sdat;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          flip;
  logic          fall;

  state_t        state;
  logic [2:0]    bcnt;
  logic [7:0]    sr;
  logic          par;
  logic          done;
  logic          perr_q;
  logic          tmo;

  logic          ext_f;
  logic          brk_f;
  logic          push_q;
  logic [9:0]    ev;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr;

  assign sclk = clk_s[1];
  assign sdat = dat_s[1];

  // two-flop synchronisers on both raw pins, every clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2[0]};
      dat_s <= {dat_s[0], ps2[1]};
    end
  end

  assign flip = (sclk != filt) && (fcnt == FW'(FILTER - 1));
  assign fall = ce && flip && filt;

  // clock-line filter: level flips after FILTER differing ce samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (ce) begin
      if (sclk != filt) begin
        if (flip) begin
          filt <= sclk;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign tmo = ce && !fall && (state != IDLE) &&
               (tcnt == TW'(TIMEOUT - 1));

  // stall timer: ce ticks since the last falling edge inside a frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (ce) begin
      if (fall || tmo || state == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // frame deframer, advancing on filtered falling edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      bcnt   <= '0;
      sr     <= '0;
      par    <= 1'b0;
      done   <= 1'b0;
      perr_q <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      if (tmo) begin
        state <= IDLE;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            if (!sdat) begin
              state <= DATA;
              bcnt  <= '0;
            end
          end
          DATA: begin
            sr   <= {sdat, sr[7:1]};
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= sdat;
            state <= STOP;
          end
          STOP: begin
            if (sdat && (^{sr, par})) done <= 1'b1;
            else perr_q <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // prefix folding and event staging on the tick after a good frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ext_f  <= 1'b0;
      brk_f  <= 1'b0;
      push_q <= 1'b0;
      ev     <= '0;
    end else if (ce) begin
      push_q <= 1'b0;
      if (tmo) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (done) begin
        unique case (1'b1)
          (sr == 8'hE0 || sr == 8'hE1): ext_f <= 1'b1;
          (sr == 8'hF0): brk_f <= 1'b1;
          (sr == 8'hFA || sr == 8'hAA || sr == 8'hEE ||
           sr == 8'hFE || sr == 8'hFC): begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end
          default: begin
            push_q <= 1'b1;
            ev     <= {ext_f, brk_f, sr};
            ext_f  <= 1'b0;
            brk_f  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign full = (cnt == CW'(DEPTH));
  assign push = ce && push_q;
  assign pop  = rd && valid;
  assign wr   = push && (!full || pop);

  // event storage, no reset needed behind the count
  always_ff @(posedge clock) begin
    if (wr) mem[wp] <= ev;
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign valid = (cnt != '0);
  assign code  = valid ? mem[rp][7:0] : 8'h00;
  assign brk   = valid ? mem[rp][8] : 1'b0;
  assign ext   = valid ? mem[rp][9] : 1'b0;
  assign perr  = perr_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_ps2_scan.sv
// Self-checking bench for ps2_scan against a byte-level event model.
// Covers deframing, prefixes, errors, FIFO limits, glitches and stalls.
`timescale 1ns/1ps

module tb_ps2_scan;

  localparam int FILTER  = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 7000;
  localparam int HIGH    = FILTER + 4;
  localparam int LOW     = FILTER + 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       rd = 1'b0;
  logic [1:0] ps2 = 2'b11;
  logic       valid;
  logic [7:0] code;
  logic       ext;
  logic       brk;
  logic       perr;
  logic       ovf;

  int tests_run = 0;
  int tests_failed = 0;

  logic [9:0] exp_q [$];
  logic       m_ext;
  logic       m_brk;
  logic       m_perr;
  logic       m_ovf;

  always #5 clock = ~clock;

  ps2_scan #(
    .FILTER(FILTER),
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ce(ce),
    .ps2(ps2),
    .valid(valid),
    .code(code),
    .ext(ext),
    .brk(brk),
    .rd(rd),
    .perr(perr),
    .ovf(ovf)
  );

  task automatic tick(input logic pulse_rd);
    ce = 1'b1;
    rd = pulse_rd;
    @(posedge clock);
    #1;
    ce = 1'b0;
    rd = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ps2 = 2'b11;
    ce = 1'b0;
    rd = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    ticks(4);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_perr = 1'b0;
    m_ovf = 1'b0;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input bit good);
    logic p;
    p = ~^b;
    if (!good) p = ~p;
    return {1'b1, p, b, 1'b0};
  endfunction

  // one event per good non-prefix, non-response byte
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_perr = 1'b1;
    end else if (b == 8'hE0 || b == 8'hE1) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hFA || b == 8'hAA || b == 8'hEE ||
                 b == 8'hFE || b == 8'hFC) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      if (exp_q.size() == DEPTH) m_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [10:0] bits, input int nbits,
                            input int rd_at, input bit lat_chk);
    for (int i = 0; i < nbits; i++) begin
      ps2 = {bits[i], 1'b1};
      ticks(HIGH);
      ps2 = {bits[i], 1'b0};
      for (int t = 1; t <= LOW; t++) begin
        tick(i == 10 && t == rd_at);
        if (lat_chk && i == 10 && t == FILTER + 2) begin
          tests_run++;
          if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early valid=%b want 0", valid);
          end
        end
        if (lat_chk && i == 10 && t == FILTER + 3) begin
          tests_run++;
          if (valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_push valid=%b want 1", valid);
          end
        end
      end
    end
    ps2 = 2'b11;
    ticks(HIGH);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    send_frame(frame(b, good), 11, 0, 1'b0);
    model_byte(b, good);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({valid, code, ext, brk, perr, ovf} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_state v=%b c=%h e=%b b=%b pe=%b o=%b want 0",
               valid, code, ext, brk, perr, ovf);
    end
    send_byte(8'h16, 1'b1);
    send_frame(frame(8'h1C, 1'b1), 5, 0, 1'b0);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({valid, code, perr, ovf} !== 11'd0) begin
      tests_failed++;
      $display("FAIL async_reset v=%b c=%h pe=%b o=%b want 0",
               valid, code, perr, ovf);
    end
    do_reset();
    send_byte(8'h1C, 1'b1);
    tests_run++;
    if ({valid, ext, brk, code} !== {1'b1, 2'b00, 8'h1C}) begin
      tests_failed++;
      $display("FAIL post_reset_frame v=%b c=%h want 1 1c", valid, code);
    end
  endtask

  task automatic test_make();
    do_reset();
    send_frame(frame(8'h1C, 1'b1), 11, 0, 1'b1);
    model_byte(8'h1C, 1'b1);
    tests_run++;
    if ({valid, ext, brk, code} !== {1'b1, exp_q[0]}) begin
      tests_failed++;
      $display("FAIL make_head v=%b e=%b b=%b c=%h want %h",
               valid, ext, brk, code, exp_q[0]);
    end
    rd = 1'b1;
    @(posedge clock);
    #1;
    rd = 1'b0;
    exp_q.delete(0);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL make_pop valid=%b want 0", valid);
    end
  endtask

  task automatic test_prefix();
    do_reset();
    send_byte(8'hF0, 1'b1);
    send_byte(8'h1C, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h75, 1'b1);
    while (exp_q.size() > 0) begin
      tests_run++;
      if ({valid, ext, brk, code} !== {1'b1, exp_q[0]}) begin
        tests_failed++;
        $display("FAIL prefix_event v=%b e=%b b=%b c=%h want %h",
                 valid, ext, brk, code, exp_q[0]);
      end
      rd = 1'b1;
      @(posedge clock);
      #1;
      rd = 1'b0;
      exp_q.delete(0);
    end
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL prefix_empty valid=%b want 0", valid);
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_byte(8'h1C, 1'b0);
    tests_run++;
    if ({valid, perr} !== 2'b01) begin
      tests_failed++;
      $display("FAIL parity_err v=%b pe=%b want 0 1", valid, perr);
    end
    send_byte(8'h32, 1'b1);
    tests_run++;
    if ({valid, ext, brk, code, perr} !== {1'b1, exp_q[0], m_perr}) begin
      tests_failed++;
      $display("FAIL parity_next v=%b c=%h pe=%b want c=%h pe=%b",
               valid, code, perr, exp_q[0][7:0], m_perr);
    end
    rd = 1'b1;
    @(posedge clock);
    #1;
    rd = 1'b0;
    exp_q.delete(0);
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 127));
      send_byte(b, 1'b1);
    end
    tests_run++;
    if (ovf !== m_ovf) begin
      tests_failed++;
      $display("FAIL ovf_flag ovf=%b want %b", ovf, m_ovf);
    end
    while (exp_q.size() > 0) begin
      tests_run++;
      if ({valid, ext, brk, code} !== {1'b1, exp_q[0]}) begin
        tests_failed++;
        $display("FAIL ovf_order v=%b c=%h want %h",
                 valid, code, exp_q[0][7:0]);
      end
      rd = 1'b1;
      @(posedge clock);
      #1;
      rd = 1'b0;
      exp_q.delete(0);
    end
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_last_absent valid=%b c=%h want 0", valid, code);
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 127));
      send_byte(b, 1'b1);
    end
    b = 8'($urandom_range(0, 127));
    send_frame(frame(b, 1'b1), 11, FILTER + 3, 1'b0);
    exp_q.delete(0);
    exp_q.push_back({2'b00, b});
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_rw_ovf ovf=%b want 0", ovf);
    end
    while (exp_q.size() > 0) begin
      tests_run++;
      if ({valid, ext, brk, code} !== {1'b1, exp_q[0]}) begin
        tests_failed++;
        $display("FAIL full_rw_order v=%b c=%h want %h",
                 valid, code, exp_q[0][7:0]);
      end
      rd = 1'b1;
      @(posedge clock);
      #1;
      rd = 1'b0;
      exp_q.delete(0);
    end
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_rw_count valid=%b want 0", valid);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    ps2 = 2'b00;
    ticks(FILTER - 1);
    ps2 = 2'b11;
    ticks(HIGH);
    send_byte(8'h1C, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hFA, 1'b1);
    while (exp_q.size() > 0) begin
      tests_run++;
      if ({valid, ext, brk, code} !== {1'b1, exp_q[0]}) begin
        tests_failed++;
        $display("FAIL glitch_frame v=%b c=%h want %h",
                 valid, code, exp_q[0][7:0]);
      end
      rd = 1'b1;
      @(posedge clock);
      #1;
      rd = 1'b0;
      exp_q.delete(0);
    end
    tests_run++;
    if ({valid, perr} !== 2'b00) begin
      tests_failed++;
      $display("FAIL glitch_resp v=%b pe=%b want 0 0", valid, perr);
    end
  endtask

  task automatic test_random();
    logic [7:0] resp [5];
    logic [7:0] b;
    int r;
    bit good;
    resp = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else if (r < 35) b = 8'hE1;
      else if (r < 42) b = resp[$urandom_range(0, 4)];
      else b = 8'($urandom_range(0, 127));
      good = ($urandom_range(0, 9) != 0);
      send_byte(b, good);
      if (exp_q.size() == DEPTH || $urandom_range(0, 2) == 0) begin
        while (exp_q.size() > 0) begin
          tests_run++;
          if ({valid, ext, brk, code} !== {1'b1, exp_q[0]}) begin
            tests_failed++;
            $display("FAIL rand_event v=%b e=%b b=%b c=%h want %h",
                     valid, ext, brk, code, exp_q[0]);
          end
          rd = 1'b1;
          @(posedge clock);
          #1;
          rd = 1'b0;
          exp_q.delete(0);
        end
      end
    end
    while (exp_q.size() > 0) begin
      tests_run++;
      if ({valid, ext, brk, code} !== {1'b1, exp_q[0]}) begin
        tests_failed++;
        $display("FAIL rand_tail v=%b c=%h want %h",
                 valid, code, exp_q[0]);
      end
      rd = 1'b1;
      @(posedge clock);
      #1;
      rd = 1'b0;
      exp_q.delete(0);
    end
    tests_run++;
    if ({valid, perr, ovf} !== {1'b0, m_perr, m_ovf}) begin
      tests_failed++;
      $display("FAIL rand_flags v=%b pe=%b o=%b want 0 %b %b",
               valid, perr, ovf, m_perr, m_ovf);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_frame(frame(8'($urandom_range(0, 255)), 1'b1), 4, 0, 1'b0);
    ticks(TIMEOUT + 10);
`ifdef PS2_TIMEOUT_EN
    send_byte(8'h1C, 1'b1);
    tests_run++;
    if ({valid, ext, brk, code, perr} !== {1'b1, exp_q[0], 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_recover v=%b c=%h pe=%b want 1 1c 0",
               valid, code, perr);
    end
`else
    send_frame(frame(8'h1C, 1'b1), 11, 0, 1'b0);
    tests_run++;
    if (!(perr === 1'b1 || !(valid === 1'b1 && code === 8'h1C))) begin
      tests_failed++;
      $display("FAIL stall_misframe v=%b c=%h pe=%b want misframe",
               valid, code, perr);
    end
`endif
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_make();
    test_prefix();
    test_parity();
    test_overflow();
    test_glitch();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
